// File: rtl/logic16_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit bitwise logic unit (OR/AND/XOR/NOR).
// Optional registered zero flag output: define LOGIC16_ARB_ZERO_FLAG_EN.
module logic16_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  input  logic [2*NUM_REQ-1:0]  req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [15:0]           rsp_data,
  output logic [IDW-1:0]        rsp_id
`ifdef LOGIC16_ARB_ZERO_FLAG_EN
  ,
  output logic                  rsp_zero
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state;
  logic [IDW-1:0] last;
  logic [IDW-1:0] grant;
  logic           found;
  logic           hi_found;
  logic [IDW-1:0] hi_grant;
  logic           can_accept;
  logic           accept;
  logic [15:0]    op_a;
  logic [15:0]    op_b;
  logic [1:0]     op_sel;
  logic [15:0]    result;

  // Prefer the lowest valid index above last, else wrap to the lowest valid.
  always_comb begin
    hi_found = 1'b0;
    hi_grant = '0;
    found    = 1'b0;
    grant    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hi_found && req_valid[i] && i > int'(last)) begin
        hi_found = 1'b1;
        hi_grant = IDW'(i);
      end
      if (!found && req_valid[i]) begin
        found = 1'b1;
        grant = IDW'(i);
      end
    end
    if (hi_found) begin
      grant = hi_grant;
    end
  end

  assign can_accept = (state == EMPTY) || rsp_ready;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !reset && can_accept && found &&
                     (grant == IDW'(i));
    end
  end

  assign accept = |req_ready;

  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IDW'(i)) begin
        op_a   = req_a[16*i +: 16];
        op_b   = req_b[16*i +: 16];
        op_sel = req_op[2*i +: 2];
      end
    end
  end

  always_comb begin
    unique case (op_sel)
      2'b00:   result = op_a | op_b;
      2'b01:   result = op_a & op_b;
      2'b10:   result = op_a ^ op_b;
      default: result = ~(op_a | op_b);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      last      <= IDW'(NUM_REQ - 1);
`ifdef LOGIC16_ARB_ZERO_FLAG_EN
      rsp_zero  <= 1'b0;
`endif
    end else if (accept) begin
      state     <= FULL;
      rsp_valid <= 1'b1;
      rsp_data  <= result;
      rsp_id    <= grant;
      last      <= grant;
`ifdef LOGIC16_ARB_ZERO_FLAG_EN
      rsp_zero  <= (result == 16'h0000);
`endif
    end else if (state == FULL && rsp_ready) begin
      state     <= EMPTY;
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic16_rr_arbiter.sv
// Directed vector bench for logic16_rr_arbiter (NUM_REQ=4).
module tb_logic16_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
`ifdef LOGIC16_ARB_ZERO_FLAG_EN
  logic        rsp_zero;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic16_rr_arbiter #(.NUM_REQ(4), .IDW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef LOGIC16_ARB_ZERO_FLAG_EN
    ,
    .rsp_zero  (rsp_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_vld;
    logic [15:0] exp_data;
    logic [1:0]  exp_id;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Non-valid lanes carry junk so a wrong operand mux shows up.
  task automatic set_lanes(input logic [3:0] v, input logic [15:0] a,
                           input logic [15:0] b, input logic [1:0] op);
    req_valid = v;
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = v[i] ? a : 16'hDEAD;
      req_b[16*i +: 16] = v[i] ? b : 16'hBEEF;
      req_op[2*i +: 2]  = v[i] ? op : 2'(i);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 16'h00F0, 16'h0F00, 2'b00, 1'b1,
                 4'b0001, 1'b1, 16'h0FF0, 2'd0};
    vecs[1]  = '{4'b0100, 16'hFF00, 16'hF0F0, 2'b01, 1'b1,
                 4'b0100, 1'b1, 16'hF000, 2'd2};
    vecs[2]  = '{4'b0100, 16'hFF00, 16'hF0F0, 2'b10, 1'b1,
                 4'b0100, 1'b1, 16'h0FF0, 2'd2};
    vecs[3]  = '{4'b0100, 16'hFF00, 16'hF0F0, 2'b11, 1'b1,
                 4'b0100, 1'b1, 16'h000F, 2'd2};
    vecs[4]  = '{4'b0000, 16'h0000, 16'h0000, 2'b00, 1'b1,
                 4'b0000, 1'b0, 16'h0000, 2'd0};
    vecs[5]  = '{4'b0000, 16'h0000, 16'h0000, 2'b00, 1'b1,
                 4'b0000, 1'b0, 16'h0000, 2'd0};
    vecs[6]  = '{4'b1000, 16'h1234, 16'h0000, 2'b00, 1'b1,
                 4'b1000, 1'b1, 16'h1234, 2'd3};
    vecs[7]  = '{4'b1111, 16'h5555, 16'hAAAA, 2'b10, 1'b1,
                 4'b0001, 1'b1, 16'hFFFF, 2'd0};
    vecs[8]  = '{4'b1111, 16'h5555, 16'hAAAA, 2'b10, 1'b1,
                 4'b0010, 1'b1, 16'hFFFF, 2'd1};
    vecs[9]  = '{4'b1111, 16'h5555, 16'hAAAA, 2'b10, 1'b1,
                 4'b0100, 1'b1, 16'hFFFF, 2'd2};
    vecs[10] = '{4'b1111, 16'h5555, 16'hAAAA, 2'b10, 1'b1,
                 4'b1000, 1'b1, 16'hFFFF, 2'd3};
    vecs[11] = '{4'b1111, 16'h5555, 16'hAAAA, 2'b10, 1'b1,
                 4'b0001, 1'b1, 16'hFFFF, 2'd0};
    vecs[12] = '{4'b1111, 16'h5555, 16'hAAAA, 2'b10, 1'b1,
                 4'b0010, 1'b1, 16'hFFFF, 2'd1};

    reset     = 1'b1;
    rsp_ready = 1'b1;
    set_lanes(4'b1111, 16'h1111, 16'h2222, 2'b00);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    step();
    step();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    reset = 1'b0;

    for (int k = 0; k < 13; k++) begin
      set_lanes(vecs[k].valid, vecs[k].a, vecs[k].b, vecs[k].op);
      rsp_ready = vecs[k].rdy;
      #1;
      chk($sformatf("v%0d_req_ready", k), 32'(req_ready),
          32'(vecs[k].exp_ready));
      step();
      chk($sformatf("v%0d_rsp_valid", k), 32'(rsp_valid),
          32'(vecs[k].exp_vld));
      if (vecs[k].exp_vld) begin
        chk($sformatf("v%0d_rsp_data", k), 32'(rsp_data),
            32'(vecs[k].exp_data));
        chk($sformatf("v%0d_rsp_id", k), 32'(rsp_id),
            32'(vecs[k].exp_id));
      end
    end

    // Backpressure: last=1, so requester 0 wins next.
    set_lanes(4'b0001, 16'h1234, 16'h0000, 2'b00);
    rsp_ready = 1'b1;
    #1;
    chk("bp_load_ready", 32'(req_ready), 32'h1);
    step();
    chk("bp_load_data", 32'(rsp_data), 32'h1234);
    req_valid = 4'b1111;
    req_a = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d_ready", c), 32'(req_ready), 32'h0);
      step();
      chk($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp%0d_data", c), 32'(rsp_data), 32'h1234);
      chk($sformatf("bp%0d_id", c), 32'(rsp_id), 32'h0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h2);
    step();
    chk("bp_release_data", 32'(rsp_data), 32'h2222);
    chk("bp_release_id", 32'(rsp_id), 32'h1);

    // Stall while full, then reset with only requester 2 valid.
    rsp_ready = 1'b0;
    step();
    chk("mid_stall_id", 32'(rsp_id), 32'h1);
    reset = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    step();
    reset = 1'b0;
    rsp_ready = 1'b0;
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_data", 32'(rsp_data), 32'h0);
    chk("mid_rst_id", 32'(rsp_id), 32'h0);
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h4);
    step();
    chk("post_rst_valid", 32'(rsp_valid), 32'h1);
    chk("post_rst_data", 32'(rsp_data), 32'h3333);
    chk("post_rst_id", 32'(rsp_id), 32'h2);

`ifdef LOGIC16_ARB_ZERO_FLAG_EN
    rsp_ready = 1'b1;
    set_lanes(4'b0001, 16'hAAAA, 16'hAAAA, 2'b10);
    step();
    chk("zf_xor_data", 32'(rsp_data), 32'h0);
    chk("zf_xor_zero", 32'(rsp_zero), 32'h1);
    set_lanes(4'b0001, 16'hAAAA, 16'hAAAA, 2'b00);
    step();
    chk("zf_or_data", 32'(rsp_data), 32'hAAAA);
    chk("zf_or_zero", 32'(rsp_zero), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
